gate_truth_table_checker: RTL and testbench
===========================================

# gate_truth_table_checker

Self-checking stimulus/response stage that sits directly upstream of a single-output basic logic gate (AND, OR, NAND, NOR, XOR, XNOR). On `start` it drives every input combination to the gate and waits a programmable settle time for each. It samples the gate output, compares it against the expected truth-table value for the selected gate type, and reports pass/fail, the error count and the first failing vector. It replaces hand-written per-gate `$display` benches with a synthesizable checker reusable across the whole basic-gates collection.

## Interface
Parameters:
- `N_IN`, 2, number of gate inputs (legal 1..4); vectors span 0 .. 2^N_IN-1
- `SETTLE`, 2, clock cycles each vector is held before `dut_y` is sampled (legal >= 1)
- `ERR_W`, 4, width of the mismatch counter

Ports:
- `clk`  in  1  single clock, all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  run request, sampled at a rising edge
- `gate_sel`  in  3  gate type: 000 AND, 001 OR, 010 NAND, 011 NOR, 100 XOR, 101 XNOR, 110/111 invalid
- `dut_y`  in  1  output of the gate under test
- `vec_out`  out  N_IN  input vector driven to the gate under test
- `busy`  out  1  run in progress
- `done`  out  1  run complete; held until the next accepted start or reset
- `pass`  out  1  equals `done` AND (`err_cnt` == 0)
- `err_cnt`  out  ERR_W  mismatch count; saturates at all-ones
- `fail_vec`  out  N_IN  first vector that mismatched
- `fail_valid`  out  1  `fail_vec` holds a captured value
- `cfg_err`  out  1  one-cycle pulse when a start is rejected for an invalid `gate_sel`

## Operation
- FSM states: IDLE, RUN, DONE.
- Reset, asynchronous: state IDLE. All outputs are 0, including `vec_out`, `err_cnt`, `fail_vec`, `pass` and `cfg_err`. The settle counter and latched selection are cleared.
- Start acceptance:
  - `start`=1 in IDLE or DONE with a valid `gate_sel`: latch `gate_sel`, clear `err_cnt`/`fail_valid`/`fail_vec`/`done`, set `vec_out`=0, load settle counter with SETTLE-1, go to RUN.
  - `start` with an invalid `gate_sel`: no state change and no counter or flag update, except `cfg_err`=1 for one cycle.
  - `start` during RUN is ignored; the latched `gate_sel` is unaffected by later input changes.
- RUN:
  - The settle counter decrements each cycle.
  - At the edge where the counter is 0, compare `dut_y` to the expected value f(`vec_out`) for the latched gate.
    - AND/NAND: reduction AND, without/with inversion.
    - OR/NOR: reduction OR, without/with inversion.
    - XOR/XNOR: reduction XOR, without/with inversion.
  - On mismatch: `err_cnt` increments, saturating. If `fail_valid`=0, capture `fail_vec`=`vec_out` and set `fail_valid`=1.
  - Then, if `vec_out` is the all-ones vector, go to DONE. Otherwise increment `vec_out` and reload the counter with SETTLE-1.
- DONE: `busy`=0, `done`=1. `vec_out` holds the last vector, and the results hold until the next accepted start.
- `busy` is 1 exactly while in RUN.

## Timing
- Start accepted at edge E0 → `busy`=1 and `vec_out`=0 visible after E0.
- Vector k is driven from edge E0+k·SETTLE. `dut_y` is sampled at edge E0+(k+1)·SETTLE, so the gate has SETTLE-1 full cycles plus combinational time.
- Last compare, `busy` drop and `done` rise all happen at edge E0+2^N_IN·SETTLE. Run latency is therefore 2^N_IN·SETTLE cycles.
- The error-count update and the `done` rise on the final vector occur at the same edge. `pass` is valid in the same cycle `done` first reads 1.
- `cfg_err` is high for exactly the cycle after the rejecting edge.
- Reset asserted mid-run forces IDLE immediately and does not wait for a clock edge. A run never resumes after reset.
- Back-to-back runs: `start` held high in DONE restarts at the next edge, and `done` falls at that edge.

## Test plan
- NAND, N_IN=2, SETTLE=2, bench models `dut_y`=~&`vec_out` → `vec_out` steps 0,1,2,3 every 2 cycles; `done`=1 at cycle 8 after the start edge; `pass`=1, `err_cnt`=0, `fail_valid`=0.
- NAND selected, `dut_y` stuck at 1 → `err_cnt`=1, `fail_vec`=2'b11, `fail_valid`=1, `pass`=0.
- XOR selected, NAND gate modelled → single mismatch at vector 00: `err_cnt`=1, `fail_vec`=2'b00.
- N_IN=4, ERR_W=2, OR selected, `dut_y` stuck at 0 → 15 mismatches; `err_cnt` saturates at 3; `fail_vec`=4'b0001; `done` at cycle 32.
- `gate_sel`=3'b110 with `start` → `cfg_err` pulses for 1 cycle, `busy` stays 0. A valid `start` pulsed again mid-run (cycle 3) is ignored, and the run completes at cycle 8 unchanged.
- Assert `rst` at cycle 5 of a run, asynchronously between edges → all outputs 0 immediately, state IDLE. A new start afterwards completes normally with `pass`=1.

Source files
------------

// File: rtl/gate_truth_table_checker.sv
// Stimulus/response checker for a single-output basic gate: walks every input
// vector, samples the gate after a settle time and scores it against the truth table.
module gate_truth_table_checker #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 2,
  parameter int ERR_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        gate_sel,
  input  logic              dut_y,
  output logic [N_IN-1:0]   vec_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [N_IN-1:0]   fail_vec,
  output logic              fail_valid,
  output logic              cfg_err
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [2:0]        sel_q;
  logic [CNT_W-1:0]  cnt;
  logic              sel_ok;
  logic              start_ok;
  logic              sample;
  logic              last_vec;
  logic              mismatch;

  function automatic logic gate_expect(input logic [2:0] sel, input logic [N_IN-1:0] v);
    case (sel)
      3'd0:    gate_expect = &v;
      3'd1:    gate_expect = |v;
      3'd2:    gate_expect = ~&v;
      3'd3:    gate_expect = ~|v;
      3'd4:    gate_expect = ^v;
      3'd5:    gate_expect = ~^v;
      default: gate_expect = 1'b0;
    endcase
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
    sat_inc = (&c) ? c : c + ERR_W'(1);
  endfunction

  assign sel_ok   = (gate_sel <= 3'd5);
  assign start_ok = start && sel_ok && (state != RUN);
  assign sample   = (state == RUN) && (cnt == '0);
  assign last_vec = &vec_out;
  assign mismatch = (dut_y != gate_expect(sel_q, vec_out));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = RUN;
      RUN:     if (sample && last_vec) state_nxt = DONE;
      DONE:    if (start_ok) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
    pass = done && (err_cnt == '0);
  end

  // Vector walk, settle timing and scoring; an invalid start only raises cfg_err.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q      <= '0;
      cnt        <= '0;
      vec_out    <= '0;
      err_cnt    <= '0;
      fail_vec   <= '0;
      fail_valid <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      cfg_err <= start && !sel_ok && (state != RUN);
      if (start_ok) begin
        sel_q      <= gate_sel;
        err_cnt    <= '0;
        fail_valid <= 1'b0;
        fail_vec   <= '0;
        vec_out    <= '0;
        cnt        <= CNT_RELOAD;
      end else if (state == RUN) begin
        if (cnt != '0) begin
          cnt <= cnt - CNT_W'(1);
        end else begin
          if (mismatch) begin
            err_cnt <= sat_inc(err_cnt);
            if (!fail_valid) begin
              fail_vec   <= vec_out;
              fail_valid <= 1'b1;
            end
          end
          if (!last_vec) begin
            vec_out <= vec_out + N_IN'(1);
            cnt     <= CNT_RELOAD;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Directed bench: a 2-input checker scoring a modelled NAND gate, plus a
// 4-input checker with a narrow error counter scoring a stuck-at-0 output.
module tb_gate_truth_table_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic       start_a = 1'b0;
  logic [2:0] gate_sel_a = 3'd0;
  logic       dut_y_a;
  logic       stuck_a = 1'b0;
  logic [1:0] vec_a;
  logic       busy_a, done_a, pass_a, fail_valid_a, cfg_err_a;
  logic [3:0] err_cnt_a;
  logic [1:0] fail_vec_a;

  logic       start_b = 1'b0;
  logic [2:0] gate_sel_b = 3'd0;
  logic       dut_y_b;
  logic [3:0] vec_b;
  logic       busy_b, done_b, pass_b, fail_valid_b, cfg_err_b;
  logic [1:0] err_cnt_b;
  logic [3:0] fail_vec_b;

  int checks = 0;
  int errors = 0;
  int lat;

  always #5 clk = ~clk;

  // Gate under test for the 2-input checker: a NAND, optionally stuck at 1.
  always_comb dut_y_a = stuck_a ? 1'b1 : ~&vec_a;
  assign dut_y_b = 1'b0;

  gate_truth_table_checker #(.N_IN(2), .SETTLE(2), .ERR_W(4)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .gate_sel(gate_sel_a), .dut_y(dut_y_a),
    .vec_out(vec_a), .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_cnt_a),
    .fail_vec(fail_vec_a), .fail_valid(fail_valid_a), .cfg_err(cfg_err_a)
  );

  gate_truth_table_checker #(.N_IN(4), .SETTLE(2), .ERR_W(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .gate_sel(gate_sel_b), .dut_y(dut_y_b),
    .vec_out(vec_b), .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_cnt_b),
    .fail_vec(fail_vec_b), .fail_valid(fail_valid_b), .cfg_err(cfg_err_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a run on checker A and counts cycles from the start edge to done.
  task automatic run_a(input logic [2:0] sel, input bit steps, input bit poke, output int n);
    gate_sel_a = sel;
    start_a    = 1'b1;
    tick();
    start_a = 1'b0;
    chk("a_busy_after_start", busy_a, 1'b1);
    chk("a_done_after_start", done_a, 1'b0);
    chk("a_vec_after_start", vec_a, 2'd0);
    n = 0;
    while (!done_a && n < 64) begin
      tick();
      n++;
      if (steps && (n == 1 || n == 2 || n == 5 || n == 7))
        chk("a_vec_step", vec_a, n / 2);
      if (poke && n == 3) begin
        start_a    = 1'b1;
        gate_sel_a = 3'd4;
      end
      if (poke && n == 4) start_a = 1'b0;
    end
  endtask

  initial begin
    // Reset state
    #2 rst = 1'b1;
    tick();
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_done", done_a, 1'b0);
    chk("rst_pass", pass_a, 1'b0);
    chk("rst_vec", vec_a, 2'd0);
    chk("rst_err", err_cnt_a, 4'd0);
    chk("rst_fail_vec", fail_vec_a, 2'd0);
    chk("rst_fail_valid", fail_valid_a, 1'b0);
    chk("rst_cfg_err", cfg_err_a, 1'b0);
    #2 rst = 1'b0;
    tick();

    // NAND against a correct NAND
    run_a(3'd2, 1'b1, 1'b0, lat);
    chk("nand_latency", lat, 8);
    chk("nand_pass", pass_a, 1'b1);
    chk("nand_err", err_cnt_a, 4'd0);
    chk("nand_fail_valid", fail_valid_a, 1'b0);
    chk("nand_busy_done", busy_a, 1'b0);
    chk("nand_vec_hold", vec_a, 2'd3);

    // NAND against a stuck-at-1 output: only vector 11 differs
    stuck_a = 1'b1;
    run_a(3'd2, 1'b0, 1'b0, lat);
    chk("stuck_latency", lat, 8);
    chk("stuck_err", err_cnt_a, 4'd1);
    chk("stuck_fail_vec", fail_vec_a, 2'b11);
    chk("stuck_fail_valid", fail_valid_a, 1'b1);
    chk("stuck_pass", pass_a, 1'b0);
    stuck_a = 1'b0;

    // XOR selected but a NAND is attached: differs only at vector 00
    run_a(3'd4, 1'b0, 1'b0, lat);
    chk("xor_err", err_cnt_a, 4'd1);
    chk("xor_fail_vec", fail_vec_a, 2'b00);
    chk("xor_pass", pass_a, 1'b0);

    // Invalid selection from DONE: one-cycle cfg_err, results untouched
    gate_sel_a = 3'b110;
    start_a    = 1'b1;
    tick();
    start_a = 1'b0;
    chk("cfg_err_pulse", cfg_err_a, 1'b1);
    chk("cfg_busy", busy_a, 1'b0);
    chk("cfg_done_held", done_a, 1'b1);
    chk("cfg_err_cnt_held", err_cnt_a, 4'd1);
    tick();
    chk("cfg_err_clear", cfg_err_a, 1'b0);

    // Start pulsed mid-run with a different gate: ignored, run stays NAND
    run_a(3'd2, 1'b0, 1'b1, lat);
    chk("midrun_latency", lat, 8);
    chk("midrun_pass", pass_a, 1'b1);
    chk("midrun_err", err_cnt_a, 4'd0);

    // Asynchronous reset between edges in the middle of a run
    gate_sel_a = 3'd2;
    start_a    = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (5) tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy_a, 1'b0);
    chk("arst_vec", vec_a, 2'd0);
    chk("arst_done", done_a, 1'b0);
    #2 rst = 1'b0;
    repeat (3) tick();
    chk("arst_no_resume", busy_a, 1'b0);
    run_a(3'd2, 1'b0, 1'b0, lat);
    chk("arst_rerun_latency", lat, 8);
    chk("arst_rerun_pass", pass_a, 1'b1);

    // 4-input OR against stuck-at-0: 15 mismatches into a 2-bit counter
    gate_sel_b = 3'd1;
    start_b    = 1'b1;
    tick();
    start_b = 1'b0;
    chk("b_busy", busy_b, 1'b1);
    lat = 0;
    while (!done_b && lat < 100) begin
      tick();
      lat++;
    end
    chk("b_latency", lat, 32);
    chk("b_err_sat", err_cnt_b, 2'd3);
    chk("b_fail_vec", fail_vec_b, 4'b0001);
    chk("b_fail_valid", fail_valid_b, 1'b1);
    chk("b_pass", pass_b, 1'b0);
    chk("b_vec_hold", vec_b, 4'hf);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
